// File: rtl/sync_bank.sv
// sync_bank: WIDTH-channel flop-chain synchronizer with a registered level and one-cycle rise/fall pulses.
// Define SYNC_BANK_FILTER_EN to add a per-channel stability filter of FILTER_LEN cycles.
module sync_bank #(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  if (STAGES < 2) begin : g_stages_check
    $error("sync_bank: STAGES must be at least 2");
  end

  // r_chain[0] is the only flop allowed to go metastable; only r_chain[STAGES-1] leaves the chain.
  logic [STAGES-1:0][WIDTH-1:0] r_chain;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_sync = r_chain[STAGES-1];

`ifdef SYNC_BANK_FILTER_EN
  localparam int            CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0]         r_filt;
  logic [WIDTH-1:0][CW-1:0] r_cnt;

  // A new level must be seen FILTER_LEN edges in a row; any reversion restarts the count.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_filt[i] <= w_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sync_out = r_filt;
`else
  assign sync_out = w_sync;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= sync_out;
    end
  end

  // Pulses come only from registers, so they are glitch-free and exactly one cycle wide.
  assign rise     = sync_out & ~r_prev;
  assign fall     = ~sync_out & r_prev;
  assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_sync_bank.sv
// tb_sync_bank: random and directed stimulus for sync_bank, scored against a queue-based reference model.
// Follows SYNC_BANK_FILTER_EN so the same bench covers both builds.
module tb_sync_bank;
  localparam int WIDTH      = 4;
  localparam int STAGES     = 2;
  localparam int FILTER_LEN = 4;
  localparam int EW         = 3 * WIDTH + 1;
`ifdef SYNC_BANK_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk;
  logic             n_rst;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  int n_checks;
  int n_errors;
  int cycle;

  logic [EW-1:0] exp_q[$];

  sync_bank #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .async_in(async_in),
    .sync_out(sync_out),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    n_rst    = 1'b0;
    async_in = '0;
  end

  // Reference model: a delay line of captured inputs, a window of the last FILTER_LEN
  // synchronized samples (accept when the whole window disagrees with the held level),
  // and the previous output level for pulse generation.
  logic [WIDTH-1:0] m_pipe[STAGES];
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] m_filt;
  logic [WIDTH-1:0] m_prev;
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  bit               m_all_differ;

  always @(posedge clk) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) m_pipe[k] = '0;
      m_hist.delete();
      m_filt = '0;
      m_prev = '0;
    end else begin
      m_prev = FILT ? m_filt : m_pipe[STAGES-1];
      m_last = m_pipe[STAGES-1];
      m_hist.push_back(m_last);
      if (m_hist.size() > FILTER_LEN) void'(m_hist.pop_front());
      if (m_hist.size() == FILTER_LEN) begin
        for (int c = 0; c < WIDTH; c++) begin
          m_all_differ = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][c] == m_filt[c]) m_all_differ = 1'b0;
          if (m_all_differ) m_filt[c] = m_last[c];
        end
      end
      for (int k = STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = async_in;
    end
    m_out  = FILT ? m_filt : m_pipe[STAGES-1];
    m_rise = m_out & ~m_prev;
    m_fall = ~m_out & m_prev;
    exp_q.push_back({m_out, m_rise, m_fall, |(m_rise | m_fall)});
  end

  // scoreboard monitor: one expected record per clock, compared mid-cycle
  logic [EW-1:0] exp_rec;
  logic [EW-1:0] act_rec;

  always @(negedge clk) begin
    if (cycle > 0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL expect_queue_empty cycle=%0d", cycle);
      end else begin
        exp_rec = exp_q.pop_front();
        act_rec = {sync_out, rise, fall, any_edge};
        if (act_rec !== exp_rec) begin
          n_errors++;
          $display("FAIL outputs cycle=%0d got sync=%h rise=%h fall=%h any=%b expected sync=%h rise=%h fall=%h any=%b",
                   cycle, sync_out, rise, fall, any_edge,
                   exp_rec[EW-1 -: WIDTH], exp_rec[2*WIDTH -: WIDTH], exp_rec[WIDTH -: WIDTH], exp_rec[0]);
        end
      end
      n_checks++;
      if ((rise & fall) !== '0) begin
        n_errors++;
        $display("FAIL rise_and_fall cycle=%0d got %h expected 0", cycle, rise & fall);
      end
    end
  end

  always @(posedge clk) cycle++;

  // driver: hold (value, reset) for n edges; inputs change 1 time unit after the edge
  task automatic step(input logic [WIDTH-1:0] v, input logic rst_n, input int n);
    for (int i = 0; i < n; i++) begin
      async_in = v;
      n_rst    = rst_n;
      @(posedge clk);
      #1;
    end
  endtask

  logic [WIDTH-1:0] rv;
  int               rlen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cycle    = 0;
    #1;
    step(4'hF, 1'b0, 3);
    step(4'hF, 1'b1, 10);
    step(4'h0, 1'b1, 10);
    step(4'h2, 1'b1, 10);
    step(4'h0, 1'b1, 10);
    step(4'h5, 1'b1, 10);
    step(4'hA, 1'b1, 10);
    step(4'h0, 1'b1, 10);
    step(4'h1, 1'b1, 3);
    step(4'h0, 1'b1, 10);
    step(4'h1, 1'b1, 12);
    step(4'h0, 1'b1, 12);
    step(4'h4, 1'b1, 2);
    step(4'h4, 1'b0, 2);
    step(4'h4, 1'b1, 12);
    step(4'h0, 1'b1, 12);
    step(4'h1, 1'b1, 1);
    step(4'h0, 1'b1, 8);
    for (int i = 0; i < 120; i++) begin
      rv   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rlen = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) step(rv, 1'b0, $urandom_range(1, 3));
      step(rv, 1'b1, rlen);
    end
    step(4'h0, 1'b1, 12);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // hard time limit so the run always ends with a report
  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL timeout cycle=%0d", cycle);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_bank.md
Name: sync_bank

Overview:
- Parametrised multi-channel input synchronizer with edge detection; successor to the single-bit two-flop synchronizer.
- Brings WIDTH asynchronous inputs (buttons, external strobes, cross-domain flags) into the clk domain through a configurable-depth flop chain.
- Produces a registered level per channel plus single-cycle rise/fall pulses.
- Optionally adds a per-channel stability filter (debounce).

Parameters:
- WIDTH, 4, number of independent channels (≥1).
- STAGES, 2, synchronizer flops per channel (≥2; elaboration error if <2).
- FILTER_LEN, 4, consecutive cycles a new synchronized value must persist before acceptance (≥1; used only with SYNC_BANK_FILTER_EN).

Ports:
- clk  input  1  system clock, all flops rising-edge.
- n_rst  input  1  synchronous active-low reset, sampled on rising clk.
- async_in  input  WIDTH  asynchronous inputs, one per channel.
- sync_out  output  WIDTH  synchronized (and optionally filtered) level per channel.
- rise  output  WIDTH  one-cycle pulse when sync_out[i] goes 0→1.
- fall  output  WIDTH  one-cycle pulse when sync_out[i] goes 1→0.
- any_edge  output  1  OR-reduction of (rise | fall).

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (n_rst low at a rising clk edge clears state). No asynchronous reset path.
  - On reset, all chain stages, filter state, counters and the previous-level register clear to 0.
  - Outputs during and after reset: sync_out=0, rise=0, fall=0, any_edge=0.
- Chain:
  - Per channel, stage[0] <= async_in[i], stage[k] <= stage[k-1]. Only stage[0] may go metastable.
  - Nothing but stage[STAGES-1] is used downstream.
- Edge numbering: edge 1 is the first rising clk edge at which a new async_in value is captured into stage[0].
- Latency without filter:
  - sync_out[i] = stage[STAGES-1].
  - sync_out changes after edge STAGES (2 cycles at default).
- Filter (when compiled in):
  - Per channel: filt register plus counter of width $clog2(FILTER_LEN) (min 1 bit).
  - Each edge, if stage[STAGES-1] == filt: counter <= 0.
  - Else if counter == FILTER_LEN-1: filt <= stage[STAGES-1], counter <= 0.
  - Else: counter <= counter+1.
  - sync_out = filt. Accepted change appears after edge STAGES+FILTER_LEN.
  - Any reversion before acceptance clears the counter, so the pulse is fully rejected.
  - FILTER_LEN=1: one extra cycle of latency only.
- Edge detect:
  - prev[i] <= sync_out[i] each edge.
  - rise = sync_out & ~prev; fall = ~sync_out & prev.
  - Both are combinational from registers only, so they are glitch-free, exactly one cycle wide, and coincide with the first cycle of the new sync_out level.
- Channels are fully independent. Simultaneous changes on several channels give simultaneous pulses.
- any_edge is high for one cycle if any channel pulses.
- rise[i] and fall[i] are never both high.
- A held input produces no further pulses.
- Reset mid-operation:
  - All state clears at that edge; in-flight values are discarded.
  - If async_in is 1 when reset releases, sync_out rises after the normal latency with a rise pulse. There are no pulses during reset.
- No width arithmetic beyond the filter counter. The counter never exceeds FILTER_LEN-1 (no wrap).

Optional Feature:
- Macro: SYNC_BANK_FILTER_EN.
- Defined: per-channel stability filter instantiated as above; latency is STAGES+FILTER_LEN.
- Undefined:
  - No filt register or counter; sync_out = stage[STAGES-1]; latency is STAGES.
  - FILTER_LEN is ignored.
  - Every synchronized transition, including 1-cycle pulses that survive sampling, produces rise/fall.

Test Plan (WIDTH=4, STAGES=2, FILTER_LEN=4 unless noted):
- Reset: n_rst=0 for 3 edges with async_in=4'hF, then release → sync_out=0 during reset; 4'hF after edge 2 (no filter) or edge 6 (filter); rise=4'hF for exactly 1 cycle; any_edge=1 for that cycle.
- Latency, no filter: async_in[1] 0→1 before edge 1 → sync_out=4'h2 from edge 2; rise=4'h2 for one cycle; fall=0 throughout.
- Filter reject: filter on, async_in[0] high for 3 cycles then low → sync_out stays 0; rise/fall never assert; counter returns to 0.
- Filter accept: filter on, async_in[0] high and held → sync_out[0]=1 after edge 6; single rise pulse. Drop it and hold → fall pulse after a further 6 edges.
- Simultaneous/independent channels: async_in 4'h0→4'h5, later 4'h5→4'hA → rise=4'h5 then rise=4'hA with fall=4'h5 in the same cycle; any_edge=1 only in those cycles.
- Reset mid-operation: filter on, assert n_rst=0 two cycles into a pending accept on channel 2 → sync_out[2] stays 0, no pulse. After release with input still high, acceptance restarts from edge 1 (sync_out[2]=1 after edge 6).
